// File: rtl/i2c_target_regs.sv
// I2C target with a small byte-wide register file.
// Responds to TARGET_ADDR, supports pointer write, burst write and burst read.
// Register contents are exported in parallel on regs_o.
// SDA is open-drain, so it is expressed as an output enable (sda_oe = 1 pulls low).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | bus ignored until a START is seen
// ADDR       | shifting in the 7-bit address and the R/W bit
// ADDR_ACK   | driving the ACK for a matched address
// PTR        | shifting in the register pointer byte
// PTR_ACK    | driving the ACK for the pointer byte
// WDATA      | shifting in a data byte; it is committed on the 8th SCL rise
// WDATA_ACK  | driving the ACK for a data byte
// RDATA      | shifting out regs[pointer], MSB first
// RDATA_MACK | released, sampling the initiator's ACK/NACK
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         NUM_REGS    = 4,
    parameter int         IDX_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_stb,
    output logic [IDX_W-1:0]      wr_idx,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
    } state_t;

    state_t           state;
    logic             scl_meta, scl_sync, scl_hist;
    logic             sda_meta, sda_sync, sda_hist;
    logic [7:0]       shreg;
    logic [2:0]       bits_left;
    logic             byte_done;
    logic             rw;
    logic [IDX_W-1:0] ptr;

    logic       scl_rise, scl_fall, bus_start, bus_stop;
    logic [7:0] rx_byte, cur_byte;

    assign scl_rise  = scl_sync & ~scl_hist;
    assign scl_fall  = ~scl_sync & scl_hist;
    assign bus_start = scl_sync & scl_hist & sda_hist & ~sda_sync;
    assign bus_stop  = scl_sync & scl_hist & ~sda_hist & sda_sync;
    assign rx_byte   = {shreg[6:0], sda_sync};
    assign cur_byte  = regs_o[{ptr, 3'b000} +: 8];

    // Two-stage synchronizers plus one history stage; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_hist <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_sync <= scl_meta;
            scl_hist <= scl_sync;
            sda_meta <= sda_i;
            sda_sync <= sda_meta;
            sda_hist <= sda_sync;
        end
    end

    // Protocol FSM; sda_oe only moves on SCL fall except when START/STOP/reset release it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            regs_o    <= '0;
            wr_stb    <= 1'b0;
            wr_idx    <= '0;
            busy      <= 1'b0;
            shreg     <= '0;
            bits_left <= 3'd7;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            ptr       <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (bus_stop) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                byte_done <= 1'b0;
            end else if (bus_start) begin
                state     <= ADDR;
                sda_oe    <= 1'b0;
                bits_left <= 3'd7;
                byte_done <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg <= rx_byte;
                            if (bits_left == 3'd0) begin
                                if (rx_byte[7:1] == TARGET_ADDR) begin
                                    busy      <= 1'b1;
                                    rw        <= rx_byte[0];
                                    byte_done <= 1'b1;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                bits_left <= bits_left - 3'd1;
                            end
                        end else if (scl_fall && byte_done) begin
                            sda_oe    <= 1'b1;
                            byte_done <= 1'b0;
                            state     <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bits_left <= 3'd7;
                            if (rw) begin
                                sda_oe <= ~cur_byte[7];
                                shreg  <= {cur_byte[6:0], 1'b0};
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= PTR;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shreg <= rx_byte;
                            if (bits_left == 3'd0) begin
                                ptr       <= rx_byte[IDX_W-1:0];
                                byte_done <= 1'b1;
                            end else begin
                                bits_left <= bits_left - 3'd1;
                            end
                        end else if (scl_fall && byte_done) begin
                            sda_oe    <= 1'b1;
                            byte_done <= 1'b0;
                            state     <= PTR_ACK;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shreg <= rx_byte;
                            if (bits_left == 3'd0) begin
                                regs_o[{ptr, 3'b000} +: 8] <= rx_byte;
                                wr_stb    <= 1'b1;
                                wr_idx    <= ptr;
                                ptr       <= ptr + IDX_W'(1);
                                byte_done <= 1'b1;
                            end else begin
                                bits_left <= bits_left - 3'd1;
                            end
                        end else if (scl_fall && byte_done) begin
                            sda_oe    <= 1'b1;
                            byte_done <= 1'b0;
                            state     <= WDATA_ACK;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe    <= 1'b0;
                            bits_left <= 3'd7;
                            state     <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bits_left == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= RDATA_MACK;
                            end else begin
                                sda_oe    <= ~shreg[7];
                                shreg     <= {shreg[6:0], 1'b0};
                                bits_left <= bits_left - 3'd1;
                            end
                        end
                    end
                    RDATA_MACK: begin
                        if (scl_rise) begin
                            if (!sda_sync) begin
                                ptr       <= ptr + IDX_W'(1);
                                byte_done <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else if (scl_fall && byte_done) begin
                            // pointer already advanced on the ACK rise, so cur_byte is the next register
                            sda_oe    <= ~cur_byte[7];
                            shreg     <= {cur_byte[6:0], 1'b0};
                            bits_left <= 3'd7;
                            byte_done <= 1'b0;
                            state     <= RDATA;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: the bench plays the I2C initiator, expected
// ACKs/read bytes and expected register writes are queued at issue time and
// checked by separate monitor processes.
module tb_i2c_target_regs;

    localparam int Q = 80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        sda_m;
    logic        sda_oe;
    logic [31:0] regs_o;
    logic        wr_stb;
    logic [1:0]  wr_idx;
    logic        busy;
    logic        sda_line;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_wr_q[$];
    logic [7:0] exp_rsp_q[$];
    string      tag_q[$];
    logic [7:0] obs;
    event       rsp_ev;

    logic oe_prev = 1'b0;
    int   oe_glitch = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(.TARGET_ADDR(7'h2A), .NUM_REGS(4), .IDX_W(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scl_i  (scl),
        .sda_i  (sda_line),
        .sda_oe (sda_oe),
        .regs_o (regs_o),
        .wr_stb (wr_stb),
        .wr_idx (wr_idx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] reg_byte(input int k);
        return regs_o[k*8 +: 8];
    endfunction

    // Write-commit monitor: every wr_stb pops one expected {idx, data}.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_stb === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got idx %0d data %h expected no write", wr_idx, reg_byte(int'(wr_idx)));
            end else begin
                logic [9:0] e;
                e = exp_wr_q.pop_front();
                chk("wr_idx", {30'd0, wr_idx}, {30'd0, e[9:8]});
                chk("wr_data", {24'd0, reg_byte(int'(wr_idx))}, {24'd0, e[7:0]});
            end
        end
    end

    // Bus response monitor: ACK bits and read bytes seen by the initiator.
    always @(rsp_ev) begin
        if (exp_rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got %h expected nothing", obs);
        end else begin
            logic [7:0] e;
            string t;
            e = exp_rsp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, {24'd0, obs}, {24'd0, e});
        end
    end

    // sda_oe must never change while SCL is high; also record activity windows.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && scl === 1'b1 && sda_oe !== oe_prev) oe_glitch++;
        oe_prev = sda_oe;
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic i2c_start();
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        sda_m = 1'b0; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;  #(Q);
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        b = sda_line; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
        logic a;
        exp_rsp_q.push_back({7'd0, exp_ack});
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        obs = {7'd0, a};
        ->rsp_ev;
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic nack, input string tag);
        logic [7:0] d;
        logic b;
        exp_rsp_q.push_back(exp_d);
        tag_q.push_back(tag);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        obs = d;
        ->rsp_ev;
        send_bit(nack);
    endtask

    initial begin
        logic [7:0] b;
        rst_n = 1'b0;
        scl   = 1'b1;
        sda_m = 1'b1;
        #(4*Q);
        rst_n = 1'b1;
        #(Q);

        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_regs", regs_o, 32'h0);
        chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        chk("rst_wr_idx", {30'd0, wr_idx}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // single write: reg1 = A5
        i2c_start();
        write_byte(8'h54, 1'b0, "t1_addr_ack");
        chk("t1_busy_on", {31'd0, busy}, 32'd1);
        write_byte(8'h01, 1'b0, "t1_ptr_ack");
        exp_wr_q.push_back({2'd1, 8'hA5});
        write_byte(8'hA5, 1'b0, "t1_data_ack");
        i2c_stop();
        #(2*Q);
        chk("t1_busy_off", {31'd0, busy}, 32'd0);
        chk("t1_regs", regs_o, 32'h0000_A500);

        // burst write with pointer wrap: reg3 = 11, reg0 = 22
        i2c_start();
        write_byte(8'h54, 1'b0, "t2_addr_ack");
        write_byte(8'h03, 1'b0, "t2_ptr_ack");
        exp_wr_q.push_back({2'd3, 8'h11});
        write_byte(8'h11, 1'b0, "t2_d0_ack");
        exp_wr_q.push_back({2'd0, 8'h22});
        write_byte(8'h22, 1'b0, "t2_d1_ack");
        i2c_stop();
        #(2*Q);
        chk("t2_regs", regs_o, 32'h1100_A522);

        // reg2 = 5A so the read-back has a non-zero first byte
        i2c_start();
        write_byte(8'h54, 1'b0, "t3_pre_addr_ack");
        write_byte(8'h02, 1'b0, "t3_pre_ptr_ack");
        exp_wr_q.push_back({2'd2, 8'h5A});
        write_byte(8'h5A, 1'b0, "t3_pre_data_ack");
        i2c_stop();
        #(2*Q);

        // pointer write, repeated START, burst read reg2, reg3, reg0
        i2c_start();
        write_byte(8'h54, 1'b0, "t3_addr_ack");
        write_byte(8'h02, 1'b0, "t3_ptr_ack");
        i2c_start();
        write_byte(8'h55, 1'b0, "t3_raddr_ack");
        read_byte(8'h5A, 1'b0, "t3_rd_reg2");
        read_byte(8'h11, 1'b0, "t3_rd_reg3");
        read_byte(8'h22, 1'b1, "t3_rd_reg0");
        chk("t3_oe_after_nack", {31'd0, sda_oe}, 32'd0);
        chk("t3_busy_after_nack", {31'd0, busy}, 32'd0);
        i2c_stop();
        #(2*Q);

        // wrong address 0x2B (read): never ACKed, never busy
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        write_byte(8'h57, 1'b1, "t4_addr_nack");
        read_byte(8'hFF, 1'b1, "t4_rd_released");
        i2c_stop();
        #(2*Q);
        chk("t4_oe_seen", {31'd0, oe_seen}, 32'd0);
        chk("t4_busy_seen", {31'd0, busy_seen}, 32'd0);
        chk("t4_regs", regs_o, 32'h115A_A522);

        // STOP after 4 data bits: nothing committed, then a normal write
        i2c_start();
        write_byte(8'h54, 1'b0, "t5_addr_ack");
        write_byte(8'h00, 1'b0, "t5_ptr_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_stop();
        #(2*Q);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_oe", {31'd0, sda_oe}, 32'd0);
        chk("t5_regs_kept", regs_o, 32'h115A_A522);
        i2c_start();
        write_byte(8'h54, 1'b0, "t5_again_addr_ack");
        write_byte(8'h00, 1'b0, "t5_again_ptr_ack");
        exp_wr_q.push_back({2'd0, 8'h3C});
        write_byte(8'h3C, 1'b0, "t5_again_data_ack");
        i2c_stop();
        #(2*Q);
        chk("t5_regs_new", regs_o, 32'h115A_A53C);

        // reset while the target drives the address ACK
        i2c_start();
        b = 8'h54;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1;
        #(Q);
        chk("t6_ack_drive", {31'd0, sda_oe}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("t6_rst_regs", regs_o, 32'h0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        #50;
        rst_n = 1'b1;
        #(Q);
        i2c_start();
        write_byte(8'h54, 1'b0, "t6_addr_ack");
        write_byte(8'h01, 1'b0, "t6_ptr_ack");
        exp_wr_q.push_back({2'd1, 8'h77});
        write_byte(8'h77, 1'b0, "t6_data_ack");
        i2c_stop();
        #(2*Q);
        chk("t6_regs", regs_o, 32'h0000_7700);

        chk("wr_queue_drained", exp_wr_q.size(), 32'd0);
        chk("rsp_queue_drained", exp_rsp_q.size(), 32'd0);
        chk("oe_glitch", oe_glitch, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
